// File: rtl/complement_pkg.sv
// -----------------------------------------------------------------------------
// complement_pkg
// Shared constants for the significand complement block:
//   COMP_WIDTH  - default significand width (IEEE-754 single-precision fraction)
//   comp_mode_e - operation select encoding (COMP_TWOS / COMP_ONES)
// -----------------------------------------------------------------------------
package complement_pkg;

  localparam int unsigned COMP_WIDTH = 23;

  typedef enum logic {
    COMP_TWOS = 1'b0,
    COMP_ONES = 1'b1
  } comp_mode_e;

endpackage : complement_pkg

// File: rtl/complement_if.sv
// -----------------------------------------------------------------------------
// complement_if
// Groups the operand/result bus of the complement block.
//   in_valid, mode, significand   : driven by the master (operand source)
//   complemented_significand,
//   out_valid, zero_in, carry_out : driven by the slave (complement block)
// -----------------------------------------------------------------------------
interface complement_if
  import complement_pkg::*;
#(
  parameter int unsigned WIDTH = COMP_WIDTH
);

  logic             in_valid;
  logic             mode;
  logic [WIDTH-1:0] significand;
  logic [WIDTH-1:0] complemented_significand;
  logic             out_valid;
  logic             zero_in;
  logic             carry_out;

  modport master (
    output in_valid,
    output mode,
    output significand,
    input  complemented_significand,
    input  out_valid,
    input  zero_in,
    input  carry_out
  );

  modport slave (
    input  in_valid,
    input  mode,
    input  significand,
    output complemented_significand,
    output out_valid,
    output zero_in,
    output carry_out
  );

endinterface : complement_if

// File: rtl/complement_core.sv
// -----------------------------------------------------------------------------
// complement_core
// Purely combinational inverter + full-width incrementer.
//   mode        : COMP_TWOS -> ~significand + 1, COMP_ONES -> ~significand
//   significand : operand
//   result      : complemented operand (mod 2^WIDTH)
//   zero        : operand is all zeros
//   carry       : carry out of the +1 (two's mode only, else 0)
// -----------------------------------------------------------------------------
module complement_core
  import complement_pkg::*;
#(
  parameter int unsigned WIDTH = COMP_WIDTH
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] significand,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  logic [WIDTH-1:0] inv_s;
  logic [WIDTH-1:0] inc_sum_s;
  logic             inc_carry_s;

  // Invert, increment over WIDTH+1 bits so the carry is kept, then select by mode
  always_comb begin
    inv_s                    = ~significand;
    {inc_carry_s, inc_sum_s} = {1'b0, inv_s} + {{WIDTH{1'b0}}, 1'b1};
    zero                     = (significand == {WIDTH{1'b0}});
    result                   = inc_sum_s;
    carry                    = inc_carry_s;
    case (comp_mode_e'(mode))
      COMP_TWOS: begin
        result = inc_sum_s;
        carry  = inc_carry_s;
      end
      COMP_ONES: begin
        result = inv_s;
        carry  = 1'b0;
      end
      default: begin
        result = inc_sum_s;
        carry  = inc_carry_s;
      end
    endcase
  end

endmodule : complement_core

// File: rtl/complement.sv
// -----------------------------------------------------------------------------
// complement (top)
// One's / two's complement of a floating-point significand.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//                (unused when REGISTERED = 0)
//   bus        : complement_if slave modport (operand in, result out)
// REGISTERED = 1 gives latency 1 with a result register that holds while
// in_valid is low; REGISTERED = 0 passes the core outputs straight through.
// -----------------------------------------------------------------------------
module complement
  import complement_pkg::*;
#(
  parameter int unsigned WIDTH      = COMP_WIDTH,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  complement_if.slave  bus
);

  logic [WIDTH-1:0] core_result_s;
  logic             core_zero_s;
  logic             core_carry_s;

  complement_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .mode        (bus.mode),
    .significand (bus.significand),
    .result      (core_result_s),
    .zero        (core_zero_s),
    .carry       (core_carry_s)
  );

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] result_r;
      logic             zero_r;
      logic             carry_r;
      logic             valid_r;

      // Output registers: capture on in_valid, hold otherwise; valid tracks in_valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          result_r <= {WIDTH{1'b0}};
          zero_r   <= 1'b0;
          carry_r  <= 1'b0;
          valid_r  <= 1'b0;
        end else begin
          valid_r <= bus.in_valid;
          if (bus.in_valid) begin
            result_r <= core_result_s;
            zero_r   <= core_zero_s;
            carry_r  <= core_carry_s;
          end
        end
      end

      assign bus.complemented_significand = result_r;
      assign bus.zero_in                  = zero_r;
      assign bus.carry_out                = carry_r;
      assign bus.out_valid                = valid_r;
    end else begin : g_comb
      assign bus.complemented_significand = core_result_s;
      assign bus.zero_in                  = core_zero_s;
      assign bus.carry_out                = core_carry_s;
      assign bus.out_valid                = bus.in_valid;
    end
  endgenerate

endmodule : complement

// File: tb/tb_complement.sv
// -----------------------------------------------------------------------------
// tb_complement
// Directed self-checking bench for complement (WIDTH = 23, REGISTERED = 1).
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_complement;
  import complement_pkg::*;

  localparam int unsigned W = 23;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  complement_if #(.WIDTH(W)) bus ();

  complement #(
    .WIDTH      (W),
    .REGISTERED (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] res, input logic ov,
                           input logic zi, input logic co);
    check({tag, ".result"},    {9'd0, bus.complemented_significand}, {9'd0, res});
    check({tag, ".out_valid"}, {31'd0, bus.out_valid},               {31'd0, ov});
    check({tag, ".zero_in"},   {31'd0, bus.zero_in},                 {31'd0, zi});
    check({tag, ".carry_out"}, {31'd0, bus.carry_out},               {31'd0, co});
  endtask

  // Drive one operand on the falling edge, then sample just after the rising edge
  task automatic step(input logic v, input logic m, input logic [W-1:0] s);
    @(negedge clk);
    bus.in_valid    = v;
    bus.mode        = m;
    bus.significand = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.mode        = COMP_TWOS;
    bus.significand = 23'h000000;

    // Reset state
    #12;
    check_all("reset", 23'h000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset release
    step(1'b0, COMP_TWOS, 23'h000000);
    check_all("idle", 23'h000000, 1'b0, 1'b0, 1'b0);

    // Scenario 1: two's of zero
    step(1'b1, COMP_TWOS, 23'h000000);
    check_all("s1_twos_zero", 23'h000000, 1'b1, 1'b1, 1'b1);

    // Scenario 2
    step(1'b1, COMP_TWOS, 23'h480000);
    check_all("s2_twos", 23'h380000, 1'b1, 1'b0, 1'b0);

    // Scenario 3: one's mode
    step(1'b1, COMP_ONES, 23'h2AAAAA);
    check_all("s3_ones", 23'h555555, 1'b1, 1'b0, 1'b0);

    // Scenario 4: MSB-only maps to itself, one maps to all ones
    step(1'b1, COMP_TWOS, 23'h400000);
    check_all("s4_msb", 23'h400000, 1'b1, 1'b0, 1'b0);
    step(1'b1, COMP_TWOS, 23'h000001);
    check_all("s4_one", 23'h7FFFFF, 1'b1, 1'b0, 1'b0);

    // One's of zero: all ones, zero flagged, no carry
    step(1'b1, COMP_ONES, 23'h000000);
    check_all("ones_zero", 23'h7FFFFF, 1'b1, 1'b1, 1'b0);

    // Scenario 5: three back-to-back operands, then drop valid
    step(1'b1, COMP_TWOS, 23'h000003);
    check_all("s5_b0", 23'h7FFFFD, 1'b1, 1'b0, 1'b0);
    step(1'b1, COMP_TWOS, 23'h100000);
    check_all("s5_b1", 23'h700000, 1'b1, 1'b0, 1'b0);
    step(1'b1, COMP_ONES, 23'h000FFF);
    check_all("s5_b2", 23'h7FF000, 1'b1, 1'b0, 1'b0);
    step(1'b0, COMP_TWOS, 23'h000000);
    check_all("s5_hold0", 23'h7FF000, 1'b0, 1'b0, 1'b0);
    step(1'b0, COMP_TWOS, 23'h123456);
    check_all("s5_hold1", 23'h7FF000, 1'b0, 1'b0, 1'b0);

    // Scenario 6: asynchronous reset mid-stream
    step(1'b1, COMP_TWOS, 23'h000005);
    check_all("s6_pre", 23'h7FFFFB, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("s6_async_rst", 23'h000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("s6_in_rst", 23'h000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, COMP_TWOS, 23'h000002);
    check_all("s6_after", 23'h7FFFFE, 1'b1, 1'b0, 1'b0);
    step(1'b0, COMP_TWOS, 23'h000000);
    check_all("s6_drop", 23'h7FFFFE, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_complement
